// File: rtl/disp_pkg.sv
// Shared display constants: active-low hex segment patterns (bit 6 = g .. bit 0 = a),
// the blank pattern, the channel-select state type and the digit-count helper.
package disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_AUTO   = 2'd1,
        ST_HOLD   = 2'd2
    } scan_st_e;

    function automatic int nd_of(input int w);
        return (w + 3) / 4;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex7seg
    import disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_HEX[nib_i];

endmodule

// File: rtl/mux_disp_scan.sv
// Channel selector with manual / auto-rotate scanning, showing the selected
// channel in hex on ND registered active-low seven-segment digits.
module mux_disp_scan
    import disp_pkg::*;
#(
    parameter int NCH   = 5,
    parameter int W     = 3,
    parameter int DWELL = 50_000_000,
    localparam int SW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int ND   = nd_of(W),
    localparam int CW   = (DWELL > 2) ? $clog2(DWELL) : 1
) (
    input  logic              CLOCK_50,
    input  logic              KEY0,
    input  logic [NCH*W-1:0]  data_i,
    input  logic [SW-1:0]     sel_i,
    input  logic              mode_i,
    input  logic              hold_i,
    output logic [7*ND-1:0]   HEX,
    output logic [SW-1:0]     chan_o,
    output logic              valid_o
);

    logic [NCH*W-1:0] data_s1_q, data_s2_q;
    logic [SW-1:0]    sel_s1_q, sel_s2_q;
    logic             mode_s1_q, mode_s2_q;
    logic             hold_s1_q, hold_s2_q;

    logic [SW-1:0]    cur_q, cur_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7*ND-1:0]  hex_q, hex_d;
    logic [SW-1:0]    chan_q, chan_d;
    logic             valid_q, valid_d;

    scan_st_e         st;
    logic             legal;
    logic [W-1:0]     chan_val;
    logic [4*ND-1:0]  nib_all;
    logic [7*ND-1:0]  seg_all;

    // Mode outranks hold, hold outranks terminal count; manual keeps cnt at 0
    // so entering auto always starts a full dwell.
    always_comb begin
        cnt_d = cnt_q;
        cur_d = cur_q;
        st    = !mode_s2_q ? ST_MANUAL : (hold_s2_q ? ST_HOLD : ST_AUTO);
        case (st)
            ST_MANUAL: begin
                cnt_d = '0;
                cur_d = sel_s2_q;
            end
            ST_AUTO: begin
                if (cnt_q == CW'(DWELL - 1)) begin
                    cnt_d = '0;
                    cur_d = (cur_q >= SW'(NCH - 1)) ? '0 : cur_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        legal    = (int'(cur_q) < NCH);
        chan_val = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(cur_q) == k) chan_val = data_s2_q[k*W +: W];
        end
        nib_all          = '0;
        nib_all[W-1:0]   = chan_val;
        hex_d            = legal ? seg_all : {ND{SEG_BLANK}};
        chan_d           = cur_q;
        valid_d          = legal;
    end

    for (genvar d = 0; d < ND; d++) begin : g_dig
        hex7seg u_dig (
            .nib_i (nib_all[4*d +: 4]),
            .seg_o (seg_all[7*d +: 7])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            data_s1_q <= '0;
            data_s2_q <= '0;
            sel_s1_q  <= '0;
            sel_s2_q  <= '0;
            mode_s1_q <= 1'b0;
            mode_s2_q <= 1'b0;
            hold_s1_q <= 1'b0;
            hold_s2_q <= 1'b0;
            cur_q     <= '0;
            cnt_q     <= '0;
            hex_q     <= {ND{SEG_BLANK}};
            chan_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            data_s1_q <= data_i;
            data_s2_q <= data_s1_q;
            sel_s1_q  <= sel_i;
            sel_s2_q  <= sel_s1_q;
            mode_s1_q <= mode_i;
            mode_s2_q <= mode_s1_q;
            hold_s1_q <= hold_i;
            hold_s2_q <= hold_s1_q;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            hex_q     <= hex_d;
            chan_q    <= chan_d;
            valid_q   <= valid_d;
        end
    end

    assign HEX     = hex_q;
    assign chan_o  = chan_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_mux_disp_scan.sv
// Scoreboard bench: stimulus queues expected outputs tagged with a cycle number,
// a negedge monitor pops and compares them against two DUT configurations.
module tb_mux_disp_scan;

    logic clk = 1'b0;
    logic KEY0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Config A: NCH=5, W=3, DWELL=4
    logic [14:0] data_a;
    logic [2:0]  sel_a;
    logic        mode_a, hold_a;
    logic [6:0]  hex_a;
    logic [2:0]  chan_a;
    logic        valid_a;

    // Config B: NCH=3, W=10, DWELL=4 (three digits)
    logic [29:0] data_b;
    logic [1:0]  sel_b;
    logic        mode_b, hold_b;
    logic [20:0] hex_b;
    logic [1:0]  chan_b;
    logic        valid_b;

    mux_disp_scan #(.NCH(5), .W(3), .DWELL(4)) u_dut_a (
        .CLOCK_50 (clk),
        .KEY0     (KEY0),
        .data_i   (data_a),
        .sel_i    (sel_a),
        .mode_i   (mode_a),
        .hold_i   (hold_a),
        .HEX      (hex_a),
        .chan_o   (chan_a),
        .valid_o  (valid_a)
    );

    mux_disp_scan #(.NCH(3), .W(10), .DWELL(4)) u_dut_b (
        .CLOCK_50 (clk),
        .KEY0     (KEY0),
        .data_i   (data_b),
        .sel_i    (sel_b),
        .mode_i   (mode_b),
        .hold_i   (hold_b),
        .HEX      (hex_b),
        .chan_o   (chan_b),
        .valid_o  (valid_b)
    );

    typedef struct {
        int          cyc;
        int          id;
        logic [20:0] hex;
        logic [2:0]  chan;
        logic        valid;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic push(input int at, input int id, input logic [20:0] h,
                        input logic [2:0] ch, input logic v, input string nm);
        exp_t e;
        int   i;
        e.cyc = at; e.id = id; e.hex = h; e.chan = ch; e.valid = v; e.name = nm;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= at) i++;
        sb.insert(i, e);
    endtask

    task automatic pa(input int at, input logic [6:0] h, input logic [2:0] ch,
                      input logic v, input string nm);
        push(at, 0, {14'd0, h}, ch, v, nm);
    endtask

    task automatic pb(input int at, input logic [20:0] h, input logic [1:0] ch,
                      input logic v, input string nm);
        push(at, 1, h, {1'b0, ch}, v, nm);
    endtask

    task automatic go_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    exp_t        mon_e;
    logic [20:0] act_h;
    logic [2:0]  act_c;
    logic        act_v;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.id == 0) begin
                act_h = {14'd0, hex_a}; act_c = chan_a;         act_v = valid_a;
            end else begin
                act_h = hex_b;          act_c = {1'b0, chan_b}; act_v = valid_b;
            end
            tests++;
            if (mon_e.cyc != cyc || act_h !== mon_e.hex || act_c !== mon_e.chan ||
                act_v !== mon_e.valid) begin
                fails++;
                $display("FAIL %s @cyc %0d (due %0d): hex=%h chan=%0d valid=%b, expected hex=%h chan=%0d valid=%b",
                         mon_e.name, cyc, mon_e.cyc, act_h, act_c, act_v,
                         mon_e.hex, mon_e.chan, mon_e.valid);
            end
        end
    end

    initial begin
        KEY0   = 1'b0;
        data_a = {3'd7, 3'd3, 3'd2, 3'd1, 3'd5};
        sel_a  = 3'd0; mode_a = 1'b0; hold_a = 1'b0;
        data_b = {10'h2A7, 10'h0F3, 10'h100};
        sel_b  = 2'd2; mode_b = 1'b0; hold_b = 1'b0;

        pa(1, 7'h7F, 0, 0, "rst_a1");
        pa(2, 7'h7F, 0, 0, "rst_a2");
        pb(2, 21'h1FFFFF, 0, 0, "rst_b");

        // release: first display is channel 0 of still-zero synchronised data
        go_to(3);
        tests++;
        if (hex_a !== 7'h7F || chan_a !== 3'd0 || valid_a !== 1'b0) begin
            fails++;
            $display("FAIL d_rst_a: hex=%h chan=%0d valid=%b", hex_a, chan_a, valid_a);
        end
        tests++;
        if (hex_b !== 21'h1FFFFF || chan_b !== 2'd0 || valid_b !== 1'b0) begin
            fails++;
            $display("FAIL d_rst_b: hex=%h chan=%0d valid=%b", hex_b, chan_b, valid_b);
        end
        KEY0 = 1'b1;
        pa(4, 7'h40, 0, 1, "post_rst");
        pb(4, {7'h40, 7'h40, 7'h40}, 0, 1, "post_rst_b");
        pa(6, 7'h12, 0, 1, "rst_rel_d5");
        pb(6, {7'h79, 7'h40, 7'h40}, 0, 1, "wide_ch0");
        pb(7, {7'h24, 7'h08, 7'h78}, 2, 1, "wide_ch2");

        go_to(8);  sel_a = 3'd4;
        pa(11, 7'h12, 0, 1, "sel_pre");
        pa(12, 7'h78, 4, 1, "sel4");

        go_to(12);
        tests++;
        if (hex_a !== 7'h78 || chan_a !== 3'd4 || valid_a !== 1'b1) begin
            fails++;
            $display("FAIL d_sel4: hex=%h chan=%0d valid=%b", hex_a, chan_a, valid_a);
        end

        go_to(14); sel_a = 3'd6;
        pa(17, 7'h78, 4, 1, "oor_pre");
        pa(18, 7'h7F, 6, 0, "sel_oor");

        go_to(18);
        tests++;
        if (hex_a !== 7'h7F || valid_a !== 1'b0) begin
            fails++;
            $display("FAIL d_oor: hex=%h valid=%b", hex_a, valid_a);
        end

        go_to(20); sel_a = 3'd4;
        pa(24, 7'h78, 4, 1, "sel4_again");

        go_to(26); data_a[14:12] = 3'd2;
        pa(28, 7'h78, 4, 1, "data_pre");
        pa(29, 7'h24, 4, 1, "data_lat3");

        go_to(30); sel_a = 3'd0;
        pa(34, 7'h12, 0, 1, "sel0");

        // auto rotation through all channels and wrap
        go_to(36); mode_a = 1'b1;
        pa(42, 7'h12, 0, 1, "auto_pre");
        pa(43, 7'h79, 1, 1, "auto_c1");
        pa(46, 7'h79, 1, 1, "dwell_c1");
        pa(47, 7'h24, 2, 1, "auto_c2");
        pa(51, 7'h30, 3, 1, "auto_c3");
        pa(55, 7'h24, 4, 1, "auto_c4");
        pa(59, 7'h12, 0, 1, "auto_wrap");
        pa(63, 7'h79, 1, 1, "auto_c1b");

        // hold for 10 synchronised clocks with two dwell clocks left
        go_to(62); hold_a = 1'b1;
        pa(67, 7'h79, 1, 1, "hold_frz");
        pa(76, 7'h79, 1, 1, "hold_rem_pre");
        pa(77, 7'h24, 2, 1, "hold_resume");
        go_to(72); hold_a = 1'b0;
        pa(81, 7'h30, 3, 1, "auto_c3b");

        // mode drops on the terminal-count clock: no advance
        go_to(81); mode_a = 1'b0; sel_a = 3'd3;
        pa(84, 7'h30, 3, 1, "mtc_pre");
        pa(85, 7'h30, 3, 1, "mode_vs_tc");
        pa(86, 7'h30, 3, 1, "mode_vs_tc2");

        go_to(90); mode_a = 1'b1;
        pa(96, 7'h30, 3, 1, "reauto_pre");
        pa(97, 7'h24, 4, 1, "reauto_step");

        // asynchronous reset between clock edges
        go_to(98);
        @(posedge clk);
        #2;
        KEY0 = 1'b0;
        pa(cyc, 7'h7F, 0, 0, "arst_imm");
        pb(cyc, 21'h1FFFFF, 0, 0, "arst_imm_b");
        pa(cyc + 1, 7'h7F, 0, 0, "arst_hold");
        #1;
        tests++;
        if (hex_a !== 7'h7F || chan_a !== 3'd0 || valid_a !== 1'b0) begin
            fails++;
            $display("FAIL d_arst: hex=%h chan=%0d valid=%b", hex_a, chan_a, valid_a);
        end
        go_to(101);
        KEY0 = 1'b1;
        pa(102, 7'h40, 0, 1, "arst_rel");
        pb(102, {7'h40, 7'h40, 7'h40}, 0, 1, "arst_rel_b");
        pa(104, 7'h12, 0, 1, "arst_data");
        pb(105, {7'h24, 7'h08, 7'h78}, 2, 1, "arst_wide");
        pa(107, 7'h12, 0, 1, "arst_dwell_pre");
        pa(108, 7'h79, 1, 1, "arst_step");

        go_to(112);
        #1;
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL %s: check due at cyc %0d never reached, expected hex=%h",
                     mon_e.name, mon_e.cyc, mon_e.hex);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
